// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states,
// RISC-V load/store size codes, requester id, and the access legality rule.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // 0 = core LSU, 1 = loader/DMA
  typedef logic req_id_t;

  // True when the size code exists for this direction and the address is
  // naturally aligned for that size.
  function automatic logic access_ok(input logic       is_store,
                                     input logic [2:0] f3,
                                     input logic [1:0] byte_off);
    case (f3)
      F3_B:    return 1'b1;
      F3_H:    return !byte_off[0];
      F3_W:    return byte_off == 2'b00;
      F3_BU:   return !is_store;
      F3_HU:   return !is_store && !byte_off[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane steering for stores and alignment/extension for loads;
// purely combinational, driven by the latched request.
module dmem_lane_fmt
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        byte_off,
  input  logic [DATA_W-1:0] st_data,
  input  logic [DATA_W-1:0] ld_word,
  output logic [3:0]        st_strb,
  output logic [DATA_W-1:0] st_word,
  output logic [DATA_W-1:0] ld_data
);

  logic [DATA_W-1:0] shifted;

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned; a missing default here would infer a latch.
  always_comb begin
    st_strb = 4'b1111;
    st_word = st_data;
    case (funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << byte_off;
        st_word = {4{st_data[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << {byte_off[1], 1'b0};
        st_word = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = ld_word >> {byte_off, 3'b000};

  always_comb begin
    ld_data = ld_word;
    case (funct3)
      F3_B:  ld_data = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      F3_H:  ld_data = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      F3_BU: ld_data = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      F3_HU: ld_data = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// One access per IDLE -> ACCESS -> RESP pass; illegal requests skip ACCESS.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 req,
  input  logic [1:0]                 we,
  input  logic [1:0][DM_ADDRESS-1:0] addr,
  input  logic [1:0][DATA_W-1:0]     wdata,
  input  logic [1:0][2:0]            funct3,
  output logic [1:0]                 gnt,
  output logic [1:0]                 rsp_valid,
  output logic                       rsp_err,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic [31:0]                mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [3:0]                 mem_wr,
  output logic                       mem_rd,
  input  logic [DATA_W-1:0]          mem_rdata
);

  state_t                  state, state_next;
  req_id_t                 last_grant, win_id, id_q;
  logic                    win_ok, we_q, err_q;
  logic [DM_ADDRESS-1:0]   addr_q;
  logic [DATA_W-1:0]       wdata_q, st_word, ld_data;
  logic [2:0]              f3_q;
  logic [3:0]              st_strb;

  // On a tie, the port that did not win last time goes first.
  assign win_id = req[1] && (!req[0] || last_grant == 1'b0);
  assign win_ok = access_ok(we[win_id], funct3[win_id], addr[win_id][1:0]);

  // NOTE: state and the latched request use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      f3_q       <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && |req) begin
        last_grant <= win_id;
        id_q       <= win_id;
        we_q       <= we[win_id];
        err_q      <= !win_ok;
        addr_q     <= addr[win_id];
        wdata_q    <= wdata[win_id];
        f3_q       <= funct3[win_id];
      end
    end
  end

  dmem_lane_fmt #(.DATA_W(DATA_W)) u_lane_fmt (
    .funct3   (f3_q),
    .byte_off (addr_q[1:0]),
    .st_data  (wdata_q),
    .ld_word  (mem_rdata),
    .st_strb  (st_strb),
    .st_word  (st_word),
    .ld_data  (ld_data)
  );

  assign mem_addr  = {{(32-DM_ADDRESS){1'b0}}, addr_q[DM_ADDRESS-1:2], 2'b00};
  assign mem_wdata = st_word;

  always_comb begin
    state_next = state;
    gnt        = '0;
    mem_wr     = '0;
    mem_rd     = 1'b0;
    rsp_valid  = '0;
    rsp_err    = 1'b0;
    rsp_rdata  = '0;
    case (state)
      IDLE: begin
        if (|req) begin
          gnt[win_id] = 1'b1;
          state_next  = win_ok ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        if (we_q) mem_wr = st_strb;
        else      mem_rd = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid[id_q] = 1'b1;
        rsp_err         = err_q;
        if (!err_q && !we_q) rsp_rdata = ld_data;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A reset cycle aborts whatever is in flight: no strobes, no response.
    if (reset) begin
      state_next = IDLE;
      gnt        = '0;
      mem_wr     = '0;
      mem_rd     = 1'b0;
      rsp_valid  = '0;
      rsp_err    = 1'b0;
      rsp_rdata  = '0;
    end
  end

endmodule
